// File: rtl/jmb_pkg.sv
// Shared definitions for the sliding-window line-buffer sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package jmb_pkg;

    // Counter width for values 0..value-1. The result is never below 1, so
    // degenerate parameters still give legal vector declarations.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/jmb_wrap_counter.sv
// Modulo-MAX up counter with a combinational wrap pulse for chaining.
// Latency: value updates on the edge after inc; wrap is valid in the same cycle as inc.
// Backpressure: none, counts whenever inc is high.
//   clock, reset : single clock, asynchronous active-high reset
//   clear        : synchronous return to zero, overrides inc
//   inc          : advance by one
//   value        : current count, 0..MAX-1
//   wrap         : inc while value == MAX-1 (the count returns to zero)
module jmb_wrap_counter
    import jmb_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = clog2(MAX)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign wrap = inc & (value == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/jmb_window_ctrl.sv
// Sequencer for the line-buffer chain: counts raster pixels, drives shift/clear, flags full windows.
// Latency: win_valid one cycle after the accept of the window's bottom-right pixel.
// Backpressure: a held window (win_valid & !out_ready) drops in_ready, stalling the pixel source.
//   clock, reset         : single clock, asynchronous active-high reset
//   start                : begin a frame, honoured only when idle
//   in_valid / in_ready  : pixel handshake from the source
//   out_ready            : consumer takes the current window
//   lb_enable            : shift enable to every line buffer (same cycle as accept)
//   lb_reset_n           : synchronous clear to the line buffers, low during CLEAR
//   win_valid/row/col    : registered window, top-left coordinates
//   busy, frame_done     : not idle; one-cycle end-of-frame pulse
module jmb_window_ctrl
    import jmb_pkg::*;
#(
    parameter int SL_WIDTH  = 512,
    parameter int NUM_LINES = 480,
    parameter int KERNEL    = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          out_ready,
    output logic                          lb_enable,
    output logic                          lb_reset_n,
    output logic                          win_valid,
    output logic [clog2(NUM_LINES)-1:0]   win_row,
    output logic [clog2(SL_WIDTH)-1:0]    win_col,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int CW = clog2(SL_WIDTH);
    localparam int RW = clog2(NUM_LINES);

    localparam logic [CW-1:0] K_COL = CW'(KERNEL - 1);
    localparam logic [RW-1:0] K_ROW = RW'(KERNEL - 1);

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          clear;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_wrap;
    logic          row_wrap;
    logic          win_hit;

    assign accept    = in_valid & in_ready;
    assign lb_enable = accept;

    jmb_wrap_counter #(
        .MAX (SL_WIDTH),
        .W   (CW)
    ) u_col (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (accept),
        .value (col),
        .wrap  (col_wrap)
    );

    // Row advances on column wrap; its own wrap therefore marks the final
    // pixel of the frame.
    jmb_wrap_counter #(
        .MAX (NUM_LINES),
        .W   (RW)
    ) u_row (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (col_wrap),
        .value (row),
        .wrap  (row_wrap)
    );

    // Only pixels at or past the fill region complete a window, so the
    // subtractions below never underflow.
    assign win_hit = accept & (row >= K_ROW) & (col >= K_COL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (win_hit) begin
            win_valid <= 1'b1;
            win_row   <= row - K_ROW;
            win_col   <= col - K_COL;
        end else if (out_ready) begin
            win_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        lb_reset_n = 1'b1;
        clear      = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                lb_reset_n = 1'b0;
                clear      = 1'b1;
                state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                in_ready = ~win_valid | out_ready;
                if (row_wrap) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (~win_valid | out_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jmb_window_ctrl.sv
// Self-checking bench for jmb_window_ctrl with an 8x6 image and a 3x3 kernel.
// Latency: n/a.
// Backpressure: exercised through random and forced out_ready stalls.
module tb_jmb_window_ctrl;

    localparam int SL    = 8;
    localparam int NL    = 6;
    localparam int K     = 3;
    localparam int TOTAL = SL * NL;
    localparam int NWIN  = (SL - K + 1) * (NL - K + 1);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       lb_enable;
    logic       lb_reset_n;
    logic       win_valid;
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int exp_r[$];
    int exp_c[$];

    jmb_window_ctrl #(
        .SL_WIDTH  (SL),
        .NUM_LINES (NL),
        .KERNEL    (K)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .lb_enable  (lb_enable),
        .lb_reset_n (lb_reset_n),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    // Runs one whole frame against a pixel-index model. vpct/rpct are the
    // percentages of cycles with in_valid/out_ready high; stall forces
    // out_ready low for that many cycles once the first window appears.
    task automatic run_frame(input int vpct, input int rpct, input int stall, input bit mid_start,
                             output int n_acc, output int n_win, output int n_lben,
                             output int n_clr);
        bit hv        = 1'b0;
        int hr        = 0;
        int hc        = 0;
        bit running   = 1'b0;
        bit in_drain  = 1'b0;
        bit exp_done  = 1'b0;
        bit nxt_done  = 1'b0;
        bit finished  = 1'b0;
        bit did_start = 1'b0;
        bit exp_rdy;
        int stall_left = stall;
        int r;
        int c;
        n_acc  = 0;
        n_win  = 0;
        n_lben = 0;
        n_clr  = 0;

        @(negedge clock);
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (lb_reset_n !== 1'b0 || busy !== 1'b1 || lb_enable !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_cycle: lb_reset_n=%0b busy=%0b lb_enable=%0b in_ready=%0b, want 0 1 0 0",
                     lb_reset_n, busy, lb_enable, in_ready);
        end
        if (lb_reset_n === 1'b0) n_clr++;
        running = 1'b1;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (mid_start && !did_start && n_acc == 10) begin
                start     = 1'b1;
                did_start = 1'b1;
            end
            in_valid = ($urandom_range(99) < vpct);
            if (hv && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < rpct);
            end
            #1;
            exp_rdy = running && (!hv || out_ready);

            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: pix=%0d got %0b want %0b", n_acc, in_ready, exp_rdy);
            end
            checks++;
            if (lb_enable !== (in_valid && exp_rdy)) begin
                errors++;
                $display("FAIL lb_enable: pix=%0d got %0b want %0b", n_acc, lb_enable, in_valid && exp_rdy);
            end
            checks++;
            if (win_valid !== hv || (hv && (int'(win_row) != hr || int'(win_col) != hc))) begin
                errors++;
                $display("FAIL window: got v=%0b (%0d,%0d) want v=%0b (%0d,%0d)",
                         win_valid, win_row, win_col, hv, hr, hc);
            end
            checks++;
            if (frame_done !== exp_done) begin
                errors++;
                $display("FAIL frame_done: got %0b want %0b", frame_done, exp_done);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_frame: got %0b want 1", busy);
            end
            if (lb_reset_n === 1'b0) n_clr++;
            if (lb_enable === 1'b1) n_lben++;
            if (exp_done) finished = 1'b1;

            nxt_done = 1'b0;
            if (in_drain && (!hv || out_ready)) begin
                nxt_done = 1'b1;
                in_drain = 1'b0;
            end
            if (hv && out_ready) begin
                checks++;
                if (n_win >= NWIN) begin
                    errors++;
                    $display("FAIL extra_window: got (%0d,%0d) beyond %0d windows", win_row, win_col, NWIN);
                end else if (int'(win_row) != exp_r[n_win] || int'(win_col) != exp_c[n_win]) begin
                    errors++;
                    $display("FAIL raster_order: window %0d got (%0d,%0d) want (%0d,%0d)",
                             n_win, win_row, win_col, exp_r[n_win], exp_c[n_win]);
                end
                n_win++;
            end
            if (in_valid && exp_rdy) begin
                r = n_acc / SL;
                c = n_acc % SL;
                n_acc++;
                if (r >= K - 1 && c >= K - 1) begin
                    hv = 1'b1;
                    hr = r - (K - 1);
                    hc = c - (K - 1);
                end else if (out_ready) begin
                    hv = 1'b0;
                end
                if (n_acc == TOTAL) begin
                    running  = 1'b0;
                    in_drain = 1'b1;
                end
            end else if (out_ready) begin
                hv = 1'b0;
            end
            exp_done = nxt_done;
        end
        start = 1'b0;

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL frame_timeout: accepted %0d of %0d, windows %0d", n_acc, TOTAL, n_win);
        end
    endtask

    task automatic check_totals(input string name, input int n_acc, input int n_win,
                                input int n_lben, input int n_clr);
        checks++;
        if (n_acc != TOTAL || n_lben != TOTAL) begin
            errors++;
            $display("FAIL %s_pixels: accepts=%0d lb_enable=%0d want %0d", name, n_acc, n_lben, TOTAL);
        end
        checks++;
        if (n_win != NWIN) begin
            errors++;
            $display("FAIL %s_windows: got %0d want %0d", name, n_win, NWIN);
        end
        checks++;
        if (n_clr != 1) begin
            errors++;
            $display("FAIL %s_lb_reset_n: low for %0d cycles want 1", name, n_clr);
        end
    endtask

    task automatic test_reset;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (in_ready !== 1'b0 || lb_enable !== 1'b0 || lb_reset_n !== 1'b1 || win_valid !== 1'b0 ||
                win_row !== 3'd0 || win_col !== 3'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: rdy=%0b en=%0b lbr=%0b wv=%0b wr=%0d wc=%0d busy=%0b fd=%0b want 0 0 1 0 0 0 0 0",
                         in_ready, lb_enable, lb_reset_n, win_valid, win_row, win_col, busy, frame_done);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_rate;
        int a, w, e, c;
        run_frame(100, 100, 0, 1'b0, a, w, e, c);
        check_totals("full_rate", a, w, e, c);
        @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_frame: busy=%0b want 0", busy);
        end
    endtask

    task automatic test_backpressure;
        int a, w, e, c;
        run_frame(100, 100, 5, 1'b0, a, w, e, c);
        check_totals("backpressure", a, w, e, c);
        run_frame(100, 40, 0, 1'b0, a, w, e, c);
        check_totals("random_ready", a, w, e, c);
    endtask

    task automatic test_random_gaps;
        int a, w, e, c;
        run_frame(50, 100, 0, 1'b0, a, w, e, c);
        check_totals("gaps", a, w, e, c);
        run_frame(50, 60, 2, 1'b0, a, w, e, c);
        check_totals("gaps_stall", a, w, e, c);
    endtask

    task automatic test_mid_start;
        int a, w, e, c;
        run_frame(100, 100, 0, 1'b1, a, w, e, c);
        check_totals("mid_start", a, w, e, c);
    endtask

    task automatic test_mid_reset;
        int a, w, e, c;
        @(negedge clock);
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (25) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || lb_enable !== 1'b0 || lb_reset_n !== 1'b1 || win_valid !== 1'b0 ||
            win_row !== 3'd0 || win_col !== 3'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%0b en=%0b lbr=%0b wv=%0b wr=%0d wc=%0d busy=%0b fd=%0b want 0 0 1 0 0 0 0 0",
                     in_ready, lb_enable, lb_reset_n, win_valid, win_row, win_col, busy, frame_done);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL after_reset: frame_done=%0b busy=%0b want 0 0", frame_done, busy);
            end
        end
        run_frame(100, 100, 0, 1'b0, a, w, e, c);
        check_totals("post_reset", a, w, e, c);
    endtask

    task automatic test_back_to_back;
        int a, w, e, c;
        run_frame(100, 100, 0, 1'b0, a, w, e, c);
        check_totals("b2b_first", a, w, e, c);
        run_frame(100, 100, 0, 1'b0, a, w, e, c);
        check_totals("b2b_second", a, w, e, c);
    endtask

    initial begin
        for (int r = 0; r <= NL - K; r++) begin
            for (int c = 0; c <= SL - K; c++) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
        end
        test_reset();
        test_full_rate();
        test_backpressure();
        test_random_gaps();
        test_mid_start();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
